// File: rtl/mf_interface.sv
// Multiface-style freeze interface: arms NMI on the freeze key, pages an overlay
// ROM/RAM into 0000-3FFF and shadows write-only hardware registers into overlay RAM.
module mf_interface #(
  parameter int          RAM_AW    = 13,
  parameter logic [8:0]  ROM_PAGE  = 9'h1FF,
  parameter logic [15:0] NMI_VEC   = 16'h0066,
  parameter logic [15:0] HIDE_VEC  = 16'h0065,
  parameter logic [13:0] CTRL_PORT = 14'h3FBA,
  parameter int          CRTC_REGS = 16
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        feature_en,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        m1,
  input  logic        io_wr,
  input  logic        mem_wr,
  input  logic        key_nmi,
  output logic        nmi,
  output logic        active,
  output logic        hidden,
  output logic        rom_sel,
  output logic        ram_sel,
  output logic [22:0] rom_addr,
  output logic [7:0]  dout
);

  // Shadow offsets live in the top 8K; this sets the extra high bit for a 16K RAM.
  localparam logic [RAM_AW-1:0] HI_MASK   = ~RAM_AW'(13'h1FFF);
  localparam logic [4:0]        CRTC_MASK = 5'(CRTC_REGS - 1);

  localparam int STB_KEY = 0;
  localparam int STB_M1  = 1;
  localparam int STB_IO  = 2;

  logic [2:0] strobe_in;
  logic [2:0] strobe_cur_reg;
  logic [2:0] strobe_prev_reg;
  logic [2:0] strobe_rise;

  logic       nmi_reg, active_reg, hidden_reg;
  logic [4:0] pen_idx_reg, pen_idx_next;
  logic [4:0] crtc_idx_reg, crtc_idx_next;

  logic              ram_we_reg, ram_we_next;
  logic [RAM_AW-1:0] ram_addr_reg, ram_addr_next;
  logic [7:0]        ram_wdata_reg, ram_wdata_next;
  logic [7:0]        ram_q_reg;
  logic [7:0]        ram_mem [2**RAM_AW];

  logic        ctrl_hit, ctrl_rise;
  logic        key_rise, m1_rise;
  logic        shadow_hit;
  logic [12:0] shadow_off;

  assign strobe_in = {io_wr, m1, key_nmi};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_edge
      assign strobe_rise[gi] = strobe_cur_reg[gi] & ~strobe_prev_reg[gi];
    end
  endgenerate

  assign key_rise  = strobe_rise[STB_KEY];
  assign m1_rise   = strobe_rise[STB_M1];
  assign ctrl_hit  = (cpu_addr[15:2] == CTRL_PORT);
  assign ctrl_rise = strobe_rise[STB_IO] & ctrl_hit;

  assign nmi      = nmi_reg;
  assign active   = active_reg;
  assign hidden   = hidden_reg;
  assign rom_sel  = active_reg && (cpu_addr[15:13] == 3'd0);
  assign ram_sel  = active_reg && (cpu_addr[15:13] == 3'd1);
  assign rom_addr = {ROM_PAGE, cpu_addr[13:0]};
  assign dout     = ram_sel ? ram_q_reg : 8'hFF;

  // Shadow decode of write-only register ports.
  always_comb begin
    shadow_hit    = 1'b0;
    shadow_off    = 13'h0000;
    pen_idx_next  = pen_idx_reg;
    crtc_idx_next = crtc_idx_reg;
    if (strobe_rise[STB_IO] && !ctrl_hit) begin
      case (cpu_addr[15:8])
        8'h7F: begin
          shadow_hit = 1'b1;
          case (cpu_dout[7:6])
            2'b00: begin
              shadow_off   = 13'h1FCF;
              pen_idx_next = cpu_dout[4:0];
            end
            2'b01:   shadow_off = pen_idx_reg[4] ? 13'h1FDF : {9'h1F9, pen_idx_reg[3:0]};
            2'b10:   shadow_off = 13'h1FEF;
            default: shadow_off = 13'h1FFF;
          endcase
        end
        8'hBC: begin
          shadow_hit    = 1'b1;
          shadow_off    = 13'h1CFF;
          crtc_idx_next = cpu_dout[4:0] & CRTC_MASK;
        end
        8'hBD: begin
          shadow_hit = 1'b1;
          shadow_off = 13'h1DB0 + 13'(crtc_idx_reg);
        end
        8'hF7: begin
          shadow_hit = 1'b1;
          shadow_off = 13'h17FF;
        end
        8'hDF: begin
          shadow_hit = 1'b1;
          shadow_off = 13'h1AAC;
        end
        default: shadow_hit = 1'b0;
      endcase
    end
  end

  always_comb begin
    ram_we_next    = 1'b0;
    ram_addr_next  = cpu_addr[RAM_AW-1:0];
    ram_wdata_next = cpu_dout;
    if (ctrl_rise) begin
      ram_we_next = 1'b0;
    end else if (shadow_hit) begin
      ram_we_next   = 1'b1;
      ram_addr_next = HI_MASK | RAM_AW'(shadow_off);
    end else if (mem_wr && ram_sel && feature_en) begin
      ram_we_next = 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      strobe_cur_reg  <= '0;
      strobe_prev_reg <= '0;
      nmi_reg         <= 1'b0;
      active_reg      <= 1'b0;
      hidden_reg      <= 1'b0;
      pen_idx_reg     <= '0;
      crtc_idx_reg    <= '0;
      ram_we_reg      <= 1'b0;
      ram_addr_reg    <= '0;
      ram_wdata_reg   <= '0;
    end else begin
      strobe_cur_reg  <= strobe_in;
      strobe_prev_reg <= strobe_cur_reg;
      pen_idx_reg     <= pen_idx_next;
      crtc_idx_reg    <= crtc_idx_next;
      ram_we_reg      <= ram_we_next;
      ram_addr_reg    <= ram_addr_next;
      ram_wdata_reg   <= ram_wdata_next;

      if (!feature_en) begin
        nmi_reg    <= 1'b0;
        active_reg <= 1'b0;
        hidden_reg <= 1'b0;
      end else begin
        if (key_rise && !active_reg)
          nmi_reg <= 1'b1;
        if (nmi_reg && m1_rise && (cpu_addr == NMI_VEC)) begin
          active_reg <= 1'b1;
          hidden_reg <= 1'b0;
          nmi_reg    <= 1'b0;
        end
        if (active_reg && m1_rise && (cpu_addr == HIDE_VEC))
          hidden_reg <= 1'b1;
        // Placed last so a control-port write overrides a same-cycle activation.
        if (ctrl_rise)
          active_reg <= ~cpu_addr[1] & ~hidden_reg;
      end
    end
  end

  // Single-port overlay RAM, write-first, contents survive reset.
  always_ff @(posedge clk_sys) begin
    if (ram_we_reg)
      ram_mem[ram_addr_reg] <= ram_wdata_reg;
    ram_q_reg <= ram_we_reg ? ram_wdata_reg : ram_mem[ram_addr_reg];
  end

endmodule

// File: tb/tb_mf_interface.sv
// Scoreboarded bench for mf_interface: freeze/hide/control flow and shadow stores.
module tb_mf_interface;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        feature_en = 1'b1;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_dout = 8'h00;
  logic        m1 = 1'b0;
  logic        io_wr = 1'b0;
  logic        mem_wr = 1'b0;
  logic        key_nmi = 1'b0;
  logic        nmi, active, hidden, rom_sel, ram_sel;
  logic [22:0] rom_addr;
  logic [7:0]  dout;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } rd_exp_t;
  rd_exp_t exp_q [$];

  typedef struct {
    logic [15:0] port;
    logic [7:0]  data;
    logic [15:0] rd_addr;
    logic [7:0]  exp;
  } shadow_t;

  shadow_t shadow_tbl [12] = '{
    '{16'h7F00, 8'h03, 16'h3FCF, 8'h03},
    '{16'h7F00, 8'h54, 16'h3F93, 8'h54},
    '{16'hBC00, 8'h0C, 16'h3CFF, 8'h0C},
    '{16'hBD00, 8'h30, 16'h3DBC, 8'h30},
    '{16'hBC00, 8'h1D, 16'h3CFF, 8'h1D},
    '{16'hBD00, 8'h77, 16'h3DBD, 8'h77},
    '{16'h7F00, 8'h10, 16'h3FCF, 8'h10},
    '{16'h7F00, 8'h4A, 16'h3FDF, 8'h4A},
    '{16'h7F00, 8'h8C, 16'h3FEF, 8'h8C},
    '{16'h7F00, 8'hC5, 16'h3FFF, 8'hC5},
    '{16'hF700, 8'h82, 16'h37FF, 8'h82},
    '{16'hDF00, 8'h07, 16'h3AAC, 8'h07}
  };

  mf_interface dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .feature_en (feature_en),
    .cpu_addr   (cpu_addr),
    .cpu_dout   (cpu_dout),
    .m1         (m1),
    .io_wr      (io_wr),
    .mem_wr     (mem_wr),
    .key_nmi    (key_nmi),
    .nmi        (nmi),
    .active     (active),
    .hidden     (hidden),
    .rom_sel    (rom_sel),
    .ram_sel    (ram_sel),
    .rom_addr   (rom_addr),
    .dout       (dout)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("check %s: %0h", tag, got);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic key_pulse();
    key_nmi = 1'b1;
    tick(2);
    key_nmi = 1'b0;
    tick(2);
  endtask

  task automatic m1_fetch(input logic [15:0] addr);
    cpu_addr = addr;
    m1 = 1'b1;
    tick(2);
    m1 = 1'b0;
    tick(2);
  endtask

  task automatic io_out(input logic [15:0] port, input logic [7:0] data);
    cpu_addr = port;
    cpu_dout = data;
    io_wr = 1'b1;
    tick(3);
    io_wr = 1'b0;
    tick(2);
  endtask

  task automatic mem_write(input logic [15:0] addr, input logic [7:0] data);
    cpu_addr = addr;
    cpu_dout = data;
    mem_wr = 1'b1;
    tick(2);
    mem_wr = 1'b0;
  endtask

  // Expected byte is queued when the read is issued and retired when dout is due.
  task automatic read_ram(input string tag, input logic [15:0] addr, input logic [7:0] exp);
    rd_exp_t e;
    exp_q.push_back('{tag, exp});
    cpu_addr = addr;
    tick(2);
    e = exp_q.pop_front();
    check(e.tag, {24'h0, dout}, {24'h0, e.exp});
  endtask

  task automatic freeze();
    key_pulse();
    m1_fetch(16'h0066);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check("rst_nmi", nmi, 0);
    check("rst_active", active, 0);
    check("rst_hidden", hidden, 0);
    check("rst_rom_sel", rom_sel, 0);
    check("rst_dout", dout, 8'hFF);
    tick(2);
    reset_n = 1'b1;
    tick(2);

    // Freeze: nmi 2 cycles after key, active 1 cycle after detected M1 edge.
    key_nmi = 1'b1;
    tick(1);
    check("nmi_lat1", nmi, 0);
    tick(1);
    check("nmi_lat2", nmi, 1);
    key_nmi = 1'b0;
    tick(2);
    cpu_addr = 16'h0066;
    m1 = 1'b1;
    tick(1);
    check("act_lat1", active, 0);
    tick(1);
    check("act_lat2", active, 1);
    check("act_nmi_clr", nmi, 0);
    m1 = 1'b0;
    tick(2);
    cpu_addr = 16'h0123;
    #1;
    check("rom_sel", rom_sel, 1);
    check("rom_addr", rom_addr, 23'h7FC123);
    check("ram_sel_rom", ram_sel, 0);

    mem_write(16'h2010, 8'h5A);
    read_ram("mem_2010", 16'h2010, 8'h5A);
    check("ram_sel", ram_sel, 1);
    cpu_addr = 16'h4010;
    #1;
    check("dout_outside", dout, 8'hFF);

    foreach (shadow_tbl[i]) begin
      io_out(shadow_tbl[i].port, shadow_tbl[i].data);
      read_ram($sformatf("shadow_%0d", i), shadow_tbl[i].rd_addr, shadow_tbl[i].exp);
    end
    read_ram("shadow_pen3_kept", 16'h3F93, 8'h54);
    read_ram("shadow_crtc12_kept", 16'h3DBC, 8'h30);

    key_pulse();
    check("key_while_active", nmi, 0);

    m1_fetch(16'h0065);
    check("hide_set", hidden, 1);
    io_out(16'hFEEA, 8'h00);
    check("feea_off", active, 0);
    io_out(16'hFEE8, 8'h00);
    check("fee8_hidden", active, 0);
    check("hidden_kept", hidden, 1);

    reset_n = 1'b0;
    #1;
    check("rst2_hidden", hidden, 0);
    tick(1);
    reset_n = 1'b1;
    tick(1);
    freeze();
    check("refreeze_act", active, 1);
    io_out(16'hFEEA, 8'h00);
    check("refreeze_feea", active, 0);
    io_out(16'hFEE8, 8'h00);
    check("refreeze_fee8", active, 1);
    read_ram("mem_2010_kept", 16'h2010, 8'h5A);

    // Arm nmi while dormant, then enable via port so both are high at reset.
    io_out(16'hFEEA, 8'h00);
    key_pulse();
    io_out(16'hFEE8, 8'h00);
    check("pre_rst_nmi", nmi, 1);
    check("pre_rst_act", active, 1);
    #3;
    reset_n = 1'b0;
    #1;
    check("async_nmi", nmi, 0);
    check("async_act", active, 0);
    check("async_ram_sel", ram_sel, 0);
    tick(1);
    reset_n = 1'b1;
    tick(1);

    feature_en = 1'b0;
    tick(1);
    key_pulse();
    check("fen0_nmi", nmi, 0);
    io_out(16'hFEE8, 8'h00);
    check("fen0_act", active, 0);
    feature_en = 1'b1;
    tick(1);
    freeze();
    check("fen1_act", active, 1);
    read_ram("mem_2010_final", 16'h2010, 8'h5A);
    read_ram("shadow_after_rst", 16'h3DBC, 8'h30);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mf_interface.md
Name: mf_interface

Overview:
- Parametrised Multiface-style freeze/snapshot interface for the CPC core.
- On a user NMI key, arms the CPU NMI and pages in an overlay ROM and RAM at 0000-3FFF once the CPU fetches the NMI vector.
- Shadows write-only hardware registers (gate array, CRTC, PPI, ROM select) into overlay RAM so the freeze software can read them back.
- Sits between the motherboard CPU bus and the SDRAM/cpu_din mux in the top level.

Parameters:
- RAM_AW, 13: overlay RAM address width; RAM is 2^RAM_AW bytes, legal range 13..14.
- ROM_PAGE, 9'h1FF: SDRAM page [22:14] holding the overlay ROM.
- NMI_VEC, 16'h0066: M1 address that activates the overlay.
- HIDE_VEC, 16'h0065: M1 address, while active, that sets the hidden state.
- CTRL_PORT, 14'h3FBA: cpu_addr[15:2] match for the enable/disable ports FEE8/FEEA.
- CRTC_REGS, 16: number of shadowed CRTC registers, power of two, maximum 32.

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- feature_en  in  1  0 forces the interface dormant.
- cpu_addr  in  16  CPU address bus.
- cpu_dout  in  8  CPU write data.
- m1  in  1  opcode fetch strobe, level.
- io_wr  in  1  I/O write strobe, level.
- mem_wr  in  1  memory write strobe, level.
- key_nmi  in  1  freeze key, level.
- nmi  out  1  NMI request to the CPU.
- active  out  1  overlay paged in.
- hidden  out  1  overlay hidden; port enable is blocked.
- rom_sel  out  1  active and cpu_addr[15:13]==0.
- ram_sel  out  1  active and cpu_addr[15:13]==1.
- rom_addr  out  23  {ROM_PAGE, cpu_addr[13:0]}.
- dout  out  8  overlay RAM read data when ram_sel is high, else 8'hFF.

Behaviour:
- Async reset: nmi=0, active=0, hidden=0, pen_idx=0, crtc_idx=0, all edge registers=0, write enable=0. Overlay RAM contents are not cleared.
- Edge detection: key_nmi, m1 and io_wr are each registered once; a rising edge is cur & ~prev.
- NMI arm:
  - A key_nmi rising edge with active=0 and feature_en=1 sets nmi=1.
  - A key edge while active=1 is ignored.
- Activate: nmi=1 and an m1 rising edge with cpu_addr==NMI_VEC give, on the next cycle, active=1, hidden=0, nmi=0.
- Hide: active=1 and an m1 rising edge with cpu_addr==HIDE_VEC set hidden=1.
- Control port: an io_wr rising edge with cpu_addr[15:2]==CTRL_PORT sets active <= ~cpu_addr[1] & ~hidden. FEE8 enables unless hidden; FEEA always disables.
- Shadow store: on an io_wr rising edge that is not a control-port access, the store address is chosen by cpu_addr[15:8] and cpu_dout[7:6]. Offsets are within the top 8K of RAM; upper address bits are ones when RAM_AW=14.
  - 7F, data 00: address 1FCF; also latch pen_idx <= cpu_dout[4:0].
  - 7F, data 01: address 1FDF if pen_idx[4] is set, else {9'h1F9, pen_idx[3:0]}.
  - 7F, data 10: address 1FEF.
  - 7F, data 11: address 1FFF.
  - BC: address 1CFF; also latch crtc_idx <= cpu_dout[4:0] masked to CRTC_REGS-1.
  - BD: address 1DB0 + crtc_idx. CRTC_REGS=32 spans 1DB0-1DCF.
  - F7: address 17FF.
  - DF: address 1AAC.
  - Any other port: no store.
- RAM port is single-port and registered. Per-cycle priority:
  1. Control-port access: no write.
  2. Shadow store.
  3. mem_wr & ram_sel writes cpu_dout at cpu_addr[RAM_AW-1:0].
  4. Otherwise read at cpu_addr.
- Latency:
  - Write commits 2 cycles after the strobe edge; mem_wr is level and rewrites every cycle, which is harmless.
  - Read: dout is valid 2 cycles after cpu_addr is stable. Write-first: a read of the address just written returns the new data.
- feature_en=0: nmi is forced to 0 and active/hidden are cleared the next cycle. The RAM stays writable only via shadow stores, which continue so state stays coherent.
- Simultaneous events:
  - Activate and control-port write in the same cycle: control port wins.
  - Hide and activate cannot coincide because the vectors differ.
- rom_sel and ram_sel are combinational from active and cpu_addr. The top level must gate SDRAM writes with rom_sel|ram_sel.
- Reset mid-freeze returns to the dormant state immediately; no partial write completes after reset_n falls.

Test Plan:
- Pulse key_nmi, then m1 at 0x0066 -> nmi rises 2 cycles after the key edge, active=1 and nmi=0 one cycle after the M1 edge; rom_sel=1 for cpu_addr 0x0123 with rom_addr=0x7FC123.
- While active: mem_wr at 0x2010 with 0x5A, then read 0x2010 -> ram_sel=1, dout=0x5A 2 cycles later; dout=0xFF at cpu_addr 0x4010.
- OUT 7F,00000011 then OUT 7F,01010100 -> pen_idx=3, RAM[0x1F93]=0x54. OUT BC,0x0C then OUT BD,0x30 -> RAM[0x1DBC]=0x30.
- Active, m1 at 0x0065, OUT FEEA then OUT FEE8 -> hidden=1, active=0 and stays 0. Reset, re-freeze, OUT FEEA then OUT FEE8 -> active returns to 1.
- Second key_nmi edge while active -> nmi stays 0. feature_en=0 then key edge -> nmi stays 0.
- Assert reset_n=0 with nmi=1 and active=1 -> all outputs 0 asynchronously; RAM[0x2010] still reads 0x5A after a re-freeze.
